// File: rtl/pfiform_gearbox.sv
// pfiform_gearbox
//   Element-granular packing FIFO. Each join writes 0..LANES elements of
//   ELEM_W bits and each pop reads 0..LANES elements. This lets any join size
//   be re-packed to any pop size (e.g. 6-in / 11-out re-gearing of soft
//   values). Storage is a circular element array with wrapping pointers.
//   All logic runs on the rising edge of i_core_clk.
//
// Ports
//   i_core_clk   in   core clock
//   i_rx_rst     in   synchronous active-high reset
//   JoinEnable   in   producer presents JoinData/JoinAmout
//   JoinPermit   out  room for a full LANES-element join (registered count only)
//   JoinAmout    in   elements in this join (values > LANES act as LANES)
//   JoinData     in   element k at [k*ELEM_W +: ELEM_W], element 0 oldest
//   PopPermit    in   consumer ready
//   PopAmout     in   elements requested (values > LANES act as LANES)
//   PopEnable    out  PopAmout elements available, PopData valid
//   PopData      out  head elements, oldest in lane 0, unused lanes zero
//
// Optional build macro PFIFORM_STATUS_EN adds:
//   Level        out  current element count
//   JoinDropErr  out  sticky flag, set when a non-empty join is refused

module pfiform_gearbox #(
    parameter int ELEM_W     = 6,
    parameter int LANES      = 16,
    parameter int DEPTH_ELEM = 256,
    parameter int AMT_W      = 5
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      JoinEnable,
    output logic                      JoinPermit,
    input  logic [AMT_W-1:0]          JoinAmout,
    input  logic [LANES*ELEM_W-1:0]   JoinData,
    input  logic                      PopPermit,
    input  logic [AMT_W-1:0]          PopAmout,
    output logic                      PopEnable,
    output logic [LANES*ELEM_W-1:0]   PopData
`ifdef PFIFORM_STATUS_EN
    ,
    output logic [$clog2(DEPTH_ELEM):0] Level,
    output logic                      JoinDropErr
`endif
);

    localparam int PTR_W = $clog2(DEPTH_ELEM);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [AMT_W-1:0] LANES_AMT  = AMT_W'(LANES);
    localparam logic [CNT_W-1:0] PERMIT_MAX = CNT_W'(DEPTH_ELEM - LANES);

    logic [ELEM_W-1:0] mem [DEPTH_ELEM];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [AMT_W-1:0] join_amt;
    logic [AMT_W-1:0] pop_amt;
    logic             join_fire;
    logic             pop_fire;
    logic [AMT_W-1:0] join_add;
    logic [AMT_W-1:0] pop_sub;

    assign join_amt = (JoinAmout > LANES_AMT) ? LANES_AMT : JoinAmout;
    assign pop_amt  = (PopAmout  > LANES_AMT) ? LANES_AMT : PopAmout;

    // Permit looks only at the registered count so the producer can
    // decide to present a word without a combinational loop through JoinAmout.
    assign JoinPermit = (count <= PERMIT_MAX);
    assign PopEnable  = (pop_amt != '0) && (count >= CNT_W'(pop_amt));

    assign join_fire = JoinEnable & JoinPermit;
    assign pop_fire  = PopEnable & PopPermit;

    // Zero amounts fall out naturally: nothing is added or subtracted.
    assign join_add = join_fire ? join_amt : '0;
    assign pop_sub  = pop_fire  ? pop_amt  : '0;

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(join_add);
            rd_ptr <= rd_ptr + PTR_W'(pop_sub);
            count  <= count + CNT_W'(join_add) - CNT_W'(pop_sub);
        end
    end

    // Storage is deliberately not reset; pointer arithmetic wraps modulo
    // DEPTH_ELEM, so a multi-element write spans the boundary seamlessly.
    always_ff @(posedge i_core_clk) begin
        if (join_fire) begin
            for (int k = 0; k < LANES; k++) begin
                if (AMT_W'(k) < join_amt) begin
                    mem[wr_ptr + PTR_W'(k)] <= JoinData[k*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    // First-word-fall-through read. Gating with PopEnable keeps PopData at
    // zero when empty or after reset, where stale storage would otherwise show.
    always_comb begin
        PopData = '0;
        if (PopEnable) begin
            for (int k = 0; k < LANES; k++) begin
                if (AMT_W'(k) < pop_amt) begin
                    PopData[k*ELEM_W +: ELEM_W] = mem[rd_ptr + PTR_W'(k)];
                end
            end
        end
    end

`ifdef PFIFORM_STATUS_EN
    assign Level = count;

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            JoinDropErr <= 1'b0;
        end else if (JoinEnable && !JoinPermit && (JoinAmout != '0)) begin
            JoinDropErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pfiform_gearbox.sv
// Self-checking bench for pfiform_gearbox. A queue-based element model tracks
// FIFO contents; a negedge compare process checks every output each cycle,
// and directed phases add hand-computed literal expectations.

module tb_pfiform_gearbox;

    localparam int ELEM_W = 6;
    localparam int LANES  = 16;
    localparam int DEPTH  = 256;
    localparam int AMT_W  = 5;
    localparam int DW     = LANES * ELEM_W;

    logic             tb_sclk = 1'b0;
    logic             i_rx_rst;
    logic             JoinEnable;
    logic             JoinPermit;
    logic [AMT_W-1:0] JoinAmout;
    logic [DW-1:0]    JoinData;
    logic             PopPermit;
    logic [AMT_W-1:0] PopAmout;
    logic             PopEnable;
    logic [DW-1:0]    PopData;
`ifdef PFIFORM_STATUS_EN
    logic [8:0]       Level;
    logic             JoinDropErr;
`endif

    always #5 tb_sclk = ~tb_sclk;

    pfiform_gearbox #(
        .ELEM_W(ELEM_W), .LANES(LANES), .DEPTH_ELEM(DEPTH), .AMT_W(AMT_W)
    ) dut (
        .i_core_clk (tb_sclk),
        .i_rx_rst   (i_rx_rst),
        .JoinEnable (JoinEnable),
        .JoinPermit (JoinPermit),
        .JoinAmout  (JoinAmout),
        .JoinData   (JoinData),
        .PopPermit  (PopPermit),
        .PopAmout   (PopAmout),
        .PopEnable  (PopEnable),
        .PopData    (PopData)
`ifdef PFIFORM_STATUS_EN
        ,
        .Level      (Level),
        .JoinDropErr(JoinDropErr)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [ELEM_W-1:0] q[$];
    bit model_ok = 0;
    bit m_drop   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input logic [AMT_W-1:0] a);
        return (int'(a) > LANES) ? LANES : int'(a);
    endfunction

    // Model: contents as a plain element queue, updated on each clock edge
    // from pre-edge contents.
    always @(posedge tb_sclk) begin : model
        int ja, pa;
        bit permit, jf, pf;
        if (i_rx_rst) begin
            q.delete();
            m_drop   = 0;
            model_ok = 1;
        end else if (model_ok) begin
            ja     = clamp(JoinAmout);
            pa     = clamp(PopAmout);
            permit = (DEPTH - q.size()) >= LANES;
            jf     = JoinEnable && permit;
            pf     = PopPermit && (pa != 0) && (q.size() >= pa);
            if (JoinEnable && !permit && (JoinAmout != 0)) m_drop = 1;
            if (pf) repeat (pa) void'(q.pop_front());
            if (jf) for (int k = 0; k < ja; k++) q.push_back(JoinData[k*ELEM_W +: ELEM_W]);
        end
    end

    always @(negedge tb_sclk) begin : compare
        int pa;
        bit en;
        logic [DW-1:0] exp_d;
        if (model_ok && !i_rx_rst) begin
            pa    = clamp(PopAmout);
            en    = (pa != 0) && (q.size() >= pa);
            exp_d = '0;
            if (en) for (int k = 0; k < pa; k++) exp_d[k*ELEM_W +: ELEM_W] = q[k];
            chk("JoinPermit", JoinPermit, ((DEPTH - q.size()) >= LANES));
            chk("PopEnable", PopEnable, en);
            chk("PopData", PopData, exp_d);
`ifdef PFIFORM_STATUS_EN
            chk("Level", Level, q.size());
            chk("JoinDropErr", JoinDropErr, m_drop);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge tb_sclk);
        #1;
    endtask

    task automatic do_reset();
        i_rx_rst = 1'b1;
        tick(2);
        i_rx_rst = 1'b0;
    endtask

    logic [DW-1:0] lit;

    initial begin
        i_rx_rst   = 1'b1;
        JoinEnable = 1'b0;
        JoinAmout  = '0;
        JoinData   = '0;
        PopPermit  = 1'b0;
        PopAmout   = 5'd4;
        do_reset();

        // Reset state
        @(negedge tb_sclk);
        chk("rst_join_permit", JoinPermit, 1);
        chk("rst_pop_enable", PopEnable, 0);
        chk("rst_pop_data", PopData, 0);

        // Fill with join 6, lanes 0..15, no pops
        for (int k = 0; k < LANES; k++) JoinData[k*ELEM_W +: ELEM_W] = ELEM_W'(k);
        JoinEnable = 1'b1;
        JoinAmout  = 5'd6;
        PopAmout   = 5'd11;
        tick(100);
        @(negedge tb_sclk);
        chk("fill_model_level", q.size(), 246);
        chk("fill_join_permit", JoinPermit, 0);
        lit = '0;
        for (int k = 0; k < 11; k++) lit[k*ELEM_W +: ELEM_W] = ELEM_W'(k % 6);
        chk("fill_pop_data_11", PopData, lit);

        // Drain with pop 11, no joins
        JoinEnable = 1'b0;
        PopPermit  = 1'b1;
        tick(1);
        @(negedge tb_sclk);
        chk("drain_model_level", q.size(), 235);
        chk("drain_join_permit", JoinPermit, 1);
        tick(2);

        // Continuous join 6 / pop 11 well past several pointer wraps
        JoinEnable = 1'b1;
        for (int c = 0; c < 400; c++) begin
            JoinData = {$urandom, $urandom, $urandom};
            tick(1);
        end

        // Mixed random amounts, including clamped values above LANES
        for (int c = 0; c < 600; c++) begin
            JoinEnable = 1'($urandom_range(0, 1));
            JoinAmout  = AMT_W'($urandom_range(0, 20));
            PopPermit  = 1'($urandom_range(0, 1));
            PopAmout   = AMT_W'($urandom_range(0, 20));
            JoinData   = {$urandom, $urandom, $urandom};
            tick(1);
        end

        // Empty FIFO latency
        JoinEnable = 1'b0;
        PopPermit  = 1'b0;
        PopAmout   = 5'd4;
        do_reset();
        @(negedge tb_sclk);
        chk("empty_pop_enable", PopEnable, 0);
        for (int k = 0; k < LANES; k++) JoinData[k*ELEM_W +: ELEM_W] = ELEM_W'(k + 1);
        JoinEnable = 1'b1;
        JoinAmout  = 5'd6;
        tick(1);
        JoinEnable = 1'b0;
        @(negedge tb_sclk);
        chk("lat_pop_enable", PopEnable, 1);
        lit = '0;
        for (int k = 0; k < 4; k++) lit[k*ELEM_W +: ELEM_W] = ELEM_W'(k + 1);
        chk("lat_pop_data", PopData, lit);
        PopAmout = 5'd7;
        #1;
        chk("amt7_pop_enable", PopEnable, 0);
        PopAmout = 5'd6;
        #1;
        chk("amt6_pop_enable", PopEnable, 1);

        // Full FIFO, with JoinAmout 20 acting as 16
        do_reset();
        JoinEnable = 1'b1;
        JoinAmout  = 5'd20;
        PopAmout   = 5'd16;
        tick(16);
        JoinEnable = 1'b0;
        @(negedge tb_sclk);
        chk("full_model_level", q.size(), 256);
        chk("full_join_permit", JoinPermit, 0);
        chk("full_pop_enable", PopEnable, 1);
        JoinEnable = 1'b1;
        JoinAmout  = 5'd16;
        PopPermit  = 1'b1;
        tick(1);
        JoinEnable = 1'b0;
        PopPermit  = 1'b0;
        @(negedge tb_sclk);
        chk("drop_model_level", q.size(), 240);
        chk("drop_join_permit", JoinPermit, 1);
`ifdef PFIFORM_STATUS_EN
        chk("drop_level", Level, 240);
        chk("drop_err", JoinDropErr, 1);
`endif

        // Reset mid-stream at count 100
        do_reset();
        JoinEnable = 1'b1;
        JoinAmout  = 5'd10;
        tick(10);
        @(negedge tb_sclk);
        chk("mid_model_level", q.size(), 100);
        i_rx_rst = 1'b1;
        PopAmout = 5'd5;
        tick(1);
        i_rx_rst   = 1'b0;
        JoinEnable = 1'b0;
        @(negedge tb_sclk);
        chk("mid_rst_join_permit", JoinPermit, 1);
        chk("mid_rst_pop_enable", PopEnable, 0);
        chk("mid_rst_pop_data", PopData, 0);
        JoinData   = '0;
        JoinData[5:0] = 6'h2A;
        JoinEnable = 1'b1;
        JoinAmout  = 5'd1;
        PopAmout   = 5'd1;
        tick(1);
        JoinEnable = 1'b0;
        @(negedge tb_sclk);
        chk("mid_first_addr0", dut.mem[0], 6'h2A);
        chk("mid_first_pop", PopData, 96'h2A);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
